// File: rtl/mem_bus_arb.sv
// ----------------------------------------------------------------------------
// mem_bus_arb
// Arbitrates one single-port memory bus between the instruction-fetch port
// (if_*) and the data port (mem_*). Only one requester owns the bus at a time.
// On a tie the data port wins unless it also won the last completed transfer,
// in which case the fetch port is granted.
// A transfer can be aborted by a programmable wait timeout.
//
// Ports
//   clk, rst             : single clock, synchronous active-high reset
//   if_req/if_addr       : fetch request and address
//   if_ack/if_rdata/if_err : fetch done pulse, fetched word, abort flag
//   mem_req/we/addr/wdata/sel : data request, write flag, address, data, byte enables
//   mem_ack/mem_rdata/mem_err : data done pulse, read word, abort flag
//   bus_*                : registered single-port bus master signals
//   stallreq             : combinational stall request to the pipeline
//
// Parameter
//   TIMEOUT              : bus wait cycles before abort, 0 disables the abort
// ----------------------------------------------------------------------------
module mem_bus_arb #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        stallreq
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_BUSY  = 2'd1,
        MEM_BUSY = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_sel;
    logic        r_if_ack;
    logic [31:0] r_if_rdata;
    logic        r_if_err;
    logic        r_mem_ack;
    logic [31:0] r_mem_rdata;
    logic        r_mem_err;
    logic [7:0]  r_wait_cnt;
    logic        r_last_mem;     // 1 when the last completed transfer belonged to mem

    logic        w_grant_mem;
    logic        w_grant_if;
    logic        w_timeout_hit;
    logic        w_stallreq;

    // Grant selection and timeout match
    always_comb begin
        w_grant_mem   = 1'b0;
        w_grant_if    = 1'b0;
        w_timeout_hit = 1'b0;
        if (mem_req && (!if_req || !r_last_mem)) begin
            w_grant_mem = 1'b1;
        end else begin
            w_grant_mem = 1'b0;
        end
        w_grant_if = if_req && !w_grant_mem;
        if ((TIMEOUT != 8'd0) && (r_wait_cnt == TIMEOUT)) begin
            w_timeout_hit = 1'b1;
        end else begin
            w_timeout_hit = 1'b0;
        end
    end

    // Stall while a request is pending and its ack is not being pulsed now
    always_comb begin
        w_stallreq = 1'b0;
        if (rst) begin
            w_stallreq = 1'b0;
        end else begin
            w_stallreq = (if_req && !r_if_ack) || (mem_req && !r_mem_ack);
        end
    end

    // Arbitration FSM with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0;
            r_bus_wdata <= 32'h0;
            r_bus_sel   <= 4'h0;
            r_if_ack    <= 1'b0;
            r_if_rdata  <= 32'h0;
            r_if_err    <= 1'b0;
            r_mem_ack   <= 1'b0;
            r_mem_rdata <= 32'h0;
            r_mem_err   <= 1'b0;
            r_wait_cnt  <= 8'd0;
            r_last_mem  <= 1'b0;
        end else begin
            // ack/err are single-cycle pulses
            r_if_ack  <= 1'b0;
            r_if_err  <= 1'b0;
            r_mem_ack <= 1'b0;
            r_mem_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_mem) begin
                        r_state     <= MEM_BUSY;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= mem_we;
                        r_bus_addr  <= mem_addr;
                        r_bus_wdata <= mem_wdata;
                        r_bus_sel   <= mem_sel;
                        r_wait_cnt  <= 8'd0;
                    end else if (w_grant_if) begin
                        r_state     <= IF_BUSY;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= if_addr;
                        r_bus_wdata <= 32'h0;
                        r_bus_sel   <= 4'b1111;
                        r_wait_cnt  <= 8'd0;
                    end else begin
                        // A late or spurious bus_ack lands here and is ignored
                        r_bus_req   <= 1'b0;
                    end
                end
                IF_BUSY: begin
                    // bus_ack has priority over a simultaneous timeout match
                    if (bus_ack) begin
                        r_if_ack   <= 1'b1;
                        r_if_rdata <= bus_rdata;
                        r_bus_req  <= 1'b0;
                        r_last_mem <= 1'b0;
                        r_state    <= IDLE;
                    end else if (w_timeout_hit) begin
                        r_if_ack   <= 1'b1;
                        r_if_err   <= 1'b1;
                        r_if_rdata <= 32'h0;
                        r_bus_req  <= 1'b0;
                        r_last_mem <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                MEM_BUSY: begin
                    if (bus_ack) begin
                        r_mem_ack <= 1'b1;
                        // writes leave the read-data register untouched
                        if (!r_bus_we) begin
                            r_mem_rdata <= bus_rdata;
                        end else begin
                            r_mem_rdata <= r_mem_rdata;
                        end
                        r_bus_req  <= 1'b0;
                        r_last_mem <= 1'b1;
                        r_state    <= IDLE;
                    end else if (w_timeout_hit) begin
                        r_mem_ack   <= 1'b1;
                        r_mem_err   <= 1'b1;
                        r_mem_rdata <= 32'h0;
                        r_bus_req   <= 1'b0;
                        r_last_mem  <= 1'b1;
                        r_state     <= IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_bus_req <= 1'b0;
                end
            endcase
        end
    end

    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_sel   = r_bus_sel;
    assign if_ack    = r_if_ack;
    assign if_rdata  = r_if_rdata;
    assign if_err    = r_if_err;
    assign mem_ack   = r_mem_ack;
    assign mem_rdata = r_mem_rdata;
    assign mem_err   = r_mem_err;
    assign stallreq  = w_stallreq;

endmodule

// File: tb/tb_mem_bus_arb.sv
// ----------------------------------------------------------------------------
// tb_mem_bus_arb
// Directed testbench for mem_bus_arb. Instance dut uses the default TIMEOUT,
// instance dut_to uses TIMEOUT=4; both share the same inputs.
// Inputs change 2 time units after the rising edge, outputs are checked
// afterwards (combinational stallreq after a further 1 unit).
// ----------------------------------------------------------------------------
module tb_mem_bus_arb;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_sel;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    logic        if_ack, if_err, mem_ack, mem_err, bus_req, bus_we, stallreq;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_sel;

    logic        t_if_ack, t_if_err, t_mem_ack, t_mem_err, t_bus_req, t_bus_we, t_stallreq;
    logic [31:0] t_if_rdata, t_mem_rdata, t_bus_addr, t_bus_wdata;
    logic [3:0]  t_bus_sel;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arb dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(if_ack), .if_rdata(if_rdata), .if_err(if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stallreq(stallreq)
    );

    mem_bus_arb #(.TIMEOUT(8'd4)) dut_to (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr),
        .if_ack(t_if_ack), .if_rdata(t_if_rdata), .if_err(t_if_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_sel(mem_sel),
        .mem_ack(t_mem_ack), .mem_rdata(t_mem_rdata), .mem_err(t_mem_err),
        .bus_req(t_bus_req), .bus_we(t_bus_we), .bus_addr(t_bus_addr),
        .bus_wdata(t_bus_wdata), .bus_sel(t_bus_sel),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .stallreq(t_stallreq)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time bound reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst     = 1'b1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        bus_ack = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = 32'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0; bus_ack = 1'b0; bus_rdata = 32'h0;

        // ---------------- reset state ----------------
        tick();
        tick();
        if_req = 1'b1;
        #1;
        check_eq("rst_stall", {31'd0, stallreq}, 32'd0);
        check_eq("rst_bus_req", {31'd0, bus_req}, 32'd0);
        check_eq("rst_bus_sel", {28'd0, bus_sel}, 32'd0);
        check_eq("rst_bus_addr", bus_addr, 32'h0);
        check_eq("rst_if_rdata", if_rdata, 32'h0);
        check_eq("rst_mem_ack", {31'd0, mem_ack}, 32'd0);
        if_req = 1'b0;
        rst = 1'b0;

        // ---------------- single read, minimum latency ----------------
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_sel = 4'hF;
        #1;
        check_eq("rd_stall_n", {31'd0, stallreq}, 32'd1);
        check_eq("rd_bus_req_n", {31'd0, bus_req}, 32'd0);
        tick();
        check_eq("rd_bus_req_n1", {31'd0, bus_req}, 32'd1);
        check_eq("rd_bus_addr", bus_addr, 32'h100);
        check_eq("rd_bus_we", {31'd0, bus_we}, 32'd0);
        check_eq("rd_stall_n1", {31'd0, stallreq}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ack = 1'b0;
        check_eq("rd_mem_ack", {31'd0, mem_ack}, 32'd1);
        check_eq("rd_mem_rdata", mem_rdata, 32'hDEADBEEF);
        check_eq("rd_mem_err", {31'd0, mem_err}, 32'd0);
        check_eq("rd_bus_req_drop", {31'd0, bus_req}, 32'd0);
        check_eq("rd_stall_ack", {31'd0, stallreq}, 32'd0);
        mem_req = 1'b0;
        tick();
        check_eq("rd_mem_ack_end", {31'd0, mem_ack}, 32'd0);

        // ---------------- delayed write, bus held stable ----------------
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'h12345678; mem_sel = 4'b0011;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_eq("wr_bus_req", {31'd0, bus_req}, 32'd1);
            check_eq("wr_bus_addr", bus_addr, 32'h400);
            check_eq("wr_bus_wdata", bus_wdata, 32'h12345678);
            check_eq("wr_bus_sel", {28'd0, bus_sel}, 32'h3);
            check_eq("wr_bus_we", {31'd0, bus_we}, 32'd1);
            check_eq("wr_no_ack", {31'd0, mem_ack}, 32'd0);
            if (i == 0) begin
                mem_addr = 32'hFFF; mem_wdata = 32'h0; mem_sel = 4'hF; mem_we = 1'b0;
            end
            if (i == 5) begin
                bus_ack = 1'b1;
            end
            tick();
        end
        bus_ack = 1'b0;
        check_eq("wr_mem_ack", {31'd0, mem_ack}, 32'd1);
        check_eq("wr_mem_err", {31'd0, mem_err}, 32'd0);
        check_eq("wr_rdata_kept", mem_rdata, 32'hDEADBEEF);
        mem_req = 1'b0;
        tick();
        check_eq("wr_ack_single", {31'd0, mem_ack}, 32'd0);

        // ---------------- tie alternation mem, if, mem ----------------
        apply_reset();
        if_req = 1'b1; if_addr = 32'h200;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h300; mem_wdata = 32'hAAAA5555; mem_sel = 4'h5;
        tick();
        check_eq("alt1_addr", bus_addr, 32'h300);
        check_eq("alt1_we", {31'd0, bus_we}, 32'd1);
        check_eq("alt1_sel", {28'd0, bus_sel}, 32'h5);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        check_eq("alt1_mem_ack", {31'd0, mem_ack}, 32'd1);
        check_eq("alt1_if_ack", {31'd0, if_ack}, 32'd0);
        #1;
        check_eq("alt1_stall", {31'd0, stallreq}, 32'd1);
        tick();
        check_eq("alt2_bus_req", {31'd0, bus_req}, 32'd1);
        check_eq("alt2_addr", bus_addr, 32'h200);
        check_eq("alt2_we", {31'd0, bus_we}, 32'd0);
        check_eq("alt2_sel", {28'd0, bus_sel}, 32'hF);
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        tick();
        bus_ack = 1'b0;
        check_eq("alt2_if_ack", {31'd0, if_ack}, 32'd1);
        check_eq("alt2_if_rdata", if_rdata, 32'h11223344);
        check_eq("alt2_mem_ack", {31'd0, mem_ack}, 32'd0);
        tick();
        check_eq("alt3_addr", bus_addr, 32'h300);
        check_eq("alt3_we", {31'd0, bus_we}, 32'd1);
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0;
        if_req = 1'b0; mem_req = 1'b0;
        check_eq("alt3_mem_ack", {31'd0, mem_ack}, 32'd1);
        check_eq("alt3_mem_rdata", mem_rdata, 32'h0);
        tick();

        // ---------------- timeout abort (TIMEOUT=4 instance) ----------------
        apply_reset();
        if_req = 1'b1; if_addr = 32'h500;
        tick();
        check_eq("to_bus_req0", {31'd0, t_bus_req}, 32'd1);
        check_eq("to_bus_addr", t_bus_addr, 32'h500);
        bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ack = 1'b0;
        check_eq("to_pre_ack", {31'd0, t_if_ack}, 32'd1);
        check_eq("to_pre_rdata", t_if_rdata, 32'hCAFEF00D);
        check_eq("to_pre_err", {31'd0, t_if_err}, 32'd0);
        #1;
        check_eq("to_pre_stall", {31'd0, t_stallreq}, 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_eq("to_wait_req", {31'd0, t_bus_req}, 32'd1);
            check_eq("to_wait_ack", {31'd0, t_if_ack}, 32'd0);
            tick();
        end
        check_eq("to_abort_ack", {31'd0, t_if_ack}, 32'd1);
        check_eq("to_abort_err", {31'd0, t_if_err}, 32'd1);
        check_eq("to_abort_rdata", t_if_rdata, 32'h0);
        check_eq("to_abort_req", {31'd0, t_bus_req}, 32'd0);
        if_req = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h999;
        tick();
        bus_ack = 1'b0;
        check_eq("to_late_ack", {31'd0, t_if_ack}, 32'd0);
        check_eq("to_late_err", {31'd0, t_if_err}, 32'd0);
        check_eq("to_late_rdata", t_if_rdata, 32'h0);
        check_eq("to_late_req", {31'd0, t_bus_req}, 32'd0);

        // ---------------- reset during BUSY ----------------
        apply_reset();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h600; mem_sel = 4'hF;
        tick();
        check_eq("rb_busy1", {31'd0, bus_req}, 32'd1);
        tick();
        rst = 1'b1;
        #1;
        check_eq("rb_stall_rst", {31'd0, stallreq}, 32'd0);
        tick();
        rst = 1'b0; mem_req = 1'b0;
        bus_ack = 1'b1; bus_rdata = 32'h77;
        check_eq("rb_bus_req", {31'd0, bus_req}, 32'd0);
        check_eq("rb_mem_ack", {31'd0, mem_ack}, 32'd0);
        check_eq("rb_bus_addr", bus_addr, 32'h0);
        check_eq("rb_bus_sel", {28'd0, bus_sel}, 32'h0);
        tick();
        bus_ack = 1'b0;
        check_eq("rb_mem_ack2", {31'd0, mem_ack}, 32'd0);
        check_eq("rb_mem_rdata", mem_rdata, 32'h0);
        check_eq("rb_mem_err", {31'd0, mem_err}, 32'd0);
        check_eq("rb_bus_req2", {31'd0, bus_req}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
